// File: rtl/psram_arb_if.sv
// Signal bundle between the CPU/MCU requesters, the PSRAM arbiter and the pin adapter.
// slave is the arbiter's view; master is the surrounding system (requesters plus chip side).
interface psram_arb_if;
  logic        cpu_ce;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;

  logic        mcu_req;
  logic        mcu_we;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wdata;
  logic        mcu_ack;
  logic [7:0]  mcu_rdata;

  logic [23:0] mem_addr;
  logic [7:0]  mem_dati;
  logic [7:0]  mem_dato;
  logic        mem_ce;
  logic        mem_oe;
  logic        mem_we;
  logic        busy;

  modport slave (
    input  cpu_ce, cpu_we, cpu_addr, cpu_wdata,
    input  mcu_req, mcu_we, mcu_addr, mcu_wdata,
    input  mem_dato,
    output cpu_rdata, cpu_done, mcu_ack, mcu_rdata,
    output mem_addr, mem_dati, mem_ce, mem_oe, mem_we, busy
  );

  modport master (
    output cpu_ce, cpu_we, cpu_addr, cpu_wdata,
    output mcu_req, mcu_we, mcu_addr, mcu_wdata,
    output mem_dato,
    input  cpu_rdata, cpu_done, mcu_ack, mcu_rdata,
    input  mem_addr, mem_dati, mem_ce, mem_oe, mem_we, busy
  );
endinterface

// File: rtl/psram_arb.sv
// Shares one byte-wide PSRAM between the strobed CPU port (fixed priority) and the
// req/ack MCU port, enforcing CE pulse width and CE-inactive recovery between accesses.
module psram_arb #(
  parameter int unsigned ACC_CYC = 4,
  parameter int unsigned REC_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  psram_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, MCU_ACC, RECOVER} state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACC_CYC - 1);
  localparam logic [3:0] REC_LAST = 4'(REC_CYC - 1);

  state_t      state_reg;
  logic [2:0]  ce_sync_reg;
  logic        cpu_pend_reg;
  logic [3:0]  cnt_reg;
  logic [23:0] mem_addr_reg;
  logic [7:0]  mem_dati_reg;
  logic        mem_ce_reg;
  logic        mem_oe_reg;
  logic        mem_we_reg;
  logic [7:0]  cpu_rdata_reg;
  logic [7:0]  mcu_rdata_reg;
  logic        cpu_done_reg;
  logic        mcu_ack_reg;

  logic        cpu_edge;
  logic        cpu_req;

  // Bits [1:0] resynchronise cpu_ce; bit 2 is the previous synchronised level.
  assign cpu_edge = ce_sync_reg[1] & ~ce_sync_reg[2];
  // A fresh edge can be granted in the same cycle it is detected, saving a clock.
  assign cpu_req  = cpu_pend_reg | cpu_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_sync_reg <= 3'b000;
    end else begin
      ce_sync_reg <= {ce_sync_reg[1:0], bus.cpu_ce};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cpu_pend_reg  <= 1'b0;
      cnt_reg       <= 4'd0;
      mem_addr_reg  <= 24'd0;
      mem_dati_reg  <= 8'd0;
      mem_ce_reg    <= 1'b0;
      mem_oe_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      cpu_rdata_reg <= 8'd0;
      mcu_rdata_reg <= 8'd0;
      cpu_done_reg  <= 1'b0;
      mcu_ack_reg   <= 1'b0;
    end else begin
      cpu_done_reg <= 1'b0;
      mcu_ack_reg  <= 1'b0;
      if (cpu_edge) begin
        cpu_pend_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            state_reg    <= CPU_ACC;
            cpu_pend_reg <= 1'b0;
            mem_addr_reg <= bus.cpu_addr;
            mem_dati_reg <= bus.cpu_wdata;
            mem_we_reg   <= bus.cpu_we;
            mem_oe_reg   <= ~bus.cpu_we;
            mem_ce_reg   <= 1'b1;
            cnt_reg      <= ACC_LAST;
          end else if (bus.mcu_req) begin
            state_reg    <= MCU_ACC;
            mem_addr_reg <= bus.mcu_addr;
            mem_dati_reg <= bus.mcu_wdata;
            mem_we_reg   <= bus.mcu_we;
            mem_oe_reg   <= ~bus.mcu_we;
            mem_ce_reg   <= 1'b1;
            cnt_reg      <= ACC_LAST;
          end
        end

        CPU_ACC, MCU_ACC: begin
          if (cnt_reg == 4'd0) begin
            // Last strobe cycle: sample read data, release the chip, flag completion.
            state_reg  <= RECOVER;
            cnt_reg    <= REC_LAST;
            mem_ce_reg <= 1'b0;
            mem_oe_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            if (state_reg == CPU_ACC) begin
              cpu_done_reg <= 1'b1;
              if (mem_oe_reg) begin
                cpu_rdata_reg <= bus.mem_dato;
              end
            end else begin
              mcu_ack_reg <= 1'b1;
              if (mem_oe_reg) begin
                mcu_rdata_reg <= bus.mem_dato;
              end
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        RECOVER: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_dati  = mem_dati_reg;
  assign bus.mem_ce    = mem_ce_reg;
  assign bus.mem_oe    = mem_oe_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.cpu_done  = cpu_done_reg;
  assign bus.mcu_rdata = mcu_rdata_reg;
  assign bus.mcu_ack   = mcu_ack_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule
